// File: rtl/bt_debounce_pkg.sv
// Shared state encodings and default timing constants for board pushbutton inputs.
// Other board-input blocks import this package to stay consistent with bt_debounce.
package bt_debounce_pkg;

  localparam int unsigned CNT_W = 25;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } bt_state_t;

  // Compare value for a count of n cycles when the count starts at 'back' below n.
  function automatic logic [CNT_W-1:0] cnt_lim(input int unsigned n, input int unsigned back);
    return CNT_W'(n - back);
  endfunction

endpackage

// File: rtl/bt_debounce_if.sv
// Raw/synchronized pushbutton pair between the synchronizer and its consumer.
interface bt_debounce_if;
  logic btn_raw;
  logic btn_sync;

  modport master (input btn_raw, output btn_sync);
  modport slave  (output btn_raw, input btn_sync);
endinterface

// File: rtl/bt_sync.sv
// Two-flop synchronizer for the asynchronous pushbutton input.
module bt_sync (
  input  logic          i_clk,
  input  logic          i_rst,
  bt_debounce_if.master sif
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= sif.btn_raw;
      r_sync <= r_meta;
    end
  end

  assign sif.btn_sync = r_sync;

endmodule

// File: rtl/bt_debounce.sv
// Pushbutton debouncer with one-cycle press strobe and optional auto-repeat.
// state         | meaning
// IDLE          | released, waiting for a press
// PRESS_WAIT    | press seen, counting stable-high cycles
// HELD          | accepted press, repeat timer running
// RELEASE_WAIT  | release seen, counting stable-low cycles; repeat timer frozen
module bt_debounce
  import bt_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic         CLOCK_50,
  input  logic [17:17] V_SW,
  input  logic [3:3]   V_BT,
  output logic         G_BT_LVL,
  output logic         G_BT_PULSE,
  output logic [1:0]   G_BT_STATE
);

  // The cycle that leaves IDLE/HELD already counts as the first stable sample,
  // so the wait states finish DEBOUNCE_CYCLES-2 counts after clearing.
  localparam logic [CNT_W-1:0] STABLE_LIM = cnt_lim(DEBOUNCE_CYCLES, 2);
  localparam logic [CNT_W-1:0] DELAY_LIM  = cnt_lim(REPEAT_DELAY, 1);
  localparam logic [CNT_W-1:0] PERIOD_LIM = cnt_lim(REPEAT_PERIOD, 1);

  logic w_rst;
  logic w_sync;

  bt_state_t        r_state;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_rpt_armed;
  logic             r_lvl;
  logic             r_pulse;

  bt_debounce_if u_btn_if ();

  assign w_rst            = V_SW[17];
  assign u_btn_if.btn_raw = V_BT[3];
  assign w_sync           = u_btn_if.btn_sync;

  bt_sync u_sync (
    .i_clk (CLOCK_50),
    .i_rst (w_rst),
    .sif   (u_btn_if.master)
  );

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= ST_IDLE;
      r_stab_cnt  <= '0;
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
      r_lvl       <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rpt_cnt   <= '0;
          r_rpt_armed <= 1'b0;
          if (w_sync) begin
            r_state    <= ST_PRESS_WAIT;
            r_stab_cnt <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          r_rpt_cnt   <= '0;
          r_rpt_armed <= 1'b0;
          if (!w_sync) begin
            r_state <= ST_IDLE;
          end else if (r_stab_cnt == STABLE_LIM) begin
            r_state <= ST_HELD;
            r_lvl   <= 1'b1;
            r_pulse <= 1'b1;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_sync) begin
            r_state    <= ST_RELEASE_WAIT;
            r_stab_cnt <= '0;
          end else if (REPEAT_EN) begin
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            if (r_rpt_cnt == (r_rpt_armed ? PERIOD_LIM : DELAY_LIM)) begin
              r_pulse     <= 1'b1;
              r_rpt_cnt   <= '0;
              r_rpt_armed <= 1'b1;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_sync) begin
            r_state <= ST_HELD;
          end else if (r_stab_cnt == STABLE_LIM) begin
            r_state <= ST_IDLE;
            r_lvl   <= 1'b0;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign G_BT_LVL   = r_lvl;
  assign G_BT_PULSE = r_pulse;
  assign G_BT_STATE = r_state;

endmodule
